fifo_rr_drain_arbiter: RTL and testbench

FIFO_RR_DRAIN_ARBITER -- requirements
Module: fifo_rr_drain_arbiter

---
 rtl/fifo_rr_drain_arbiter.sv | 102 ++++++++++
 tb/tb_fifo_rr_drain_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain_arbiter.sv
// fifo_rr_drain_arbiter: drains CH_AMOUNT show-ahead FIFOs round-robin, up to
// BURST_LEN words per grant, into a single registered output with back-pressure.
module fifo_rr_drain_arbiter #(
  parameter int CH_AMOUNT  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CH_WIDTH   = $clog2(CH_AMOUNT)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [CH_AMOUNT-1:0]            fifo_empty_i,
  input  logic [CH_AMOUNT*DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic [CH_AMOUNT-1:0]            fifo_rd_o,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic [CH_WIDTH-1:0]             ch_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic                            busy_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_next;
  logic [CH_WIDTH-1:0]   grant, last_grant, next_ch;
  logic [7:0]            burst_cnt;
  logic [DATA_WIDTH-1:0] head_word;
  logic                  any_req, grant_empty, pop, burst_done;
  int                    idx;

  // Walk offsets from farthest to nearest so the last hit is the first
  // non-empty channel after last_grant; one subtraction wraps at CH_AMOUNT.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    next_ch = last_grant;
    idx     = 0;
    for (int i = CH_AMOUNT; i >= 1; i--) begin
      idx = int'(last_grant) + i;
      if (idx >= CH_AMOUNT) idx = idx - CH_AMOUNT;
      if (!fifo_empty_i[idx]) next_ch = CH_WIDTH'(idx);
    end
  end

  assign any_req     = |(~fifo_empty_i);
  assign grant_empty = fifo_empty_i[grant];
  assign head_word   = fifo_rd_data_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign pop         = (state == GRANT) && !grant_empty && (!valid_o || ready_i)
                       && (burst_cnt < 8'(BURST_LEN));
  assign burst_done  = pop && (burst_cnt == 8'(BURST_LEN - 1));
  assign busy_o      = (state == GRANT);

  always_comb begin
    state_next = state;
    fifo_rd_o  = '0;
    case (state)
      IDLE: begin
        if (any_req) state_next = GRANT;
      end
      GRANT: begin
        if (pop) fifo_rd_o[grant] = 1'b1;
        if (burst_done || grant_empty) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant      <= '0;
      last_grant <= CH_WIDTH'(CH_AMOUNT - 1);
      burst_cnt  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant     <= next_ch;
        burst_cnt <= '0;
      end
      if (pop) burst_cnt <= burst_cnt + 8'd1;
      if (state == GRANT && state_next == IDLE) last_grant <= grant;
    end
  end

  // Reset discards any word still waiting for the consumer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o  <= '0;
      ch_o    <= '0;
      valid_o <= 1'b0;
    end else if (pop) begin
      data_o  <= head_word;
      ch_o    <= grant;
      valid_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Bench for fifo_rr_drain_arbiter: two instances (4ch/burst 4, 3ch/burst 2) fed by
// queue-backed FIFOs, checked cycle by cycle against a round-robin reference model.
module tb_fifo_rr_drain_arbiter;

  localparam int DW = 8;
  localparam int NA = 4;
  localparam int BA = 4;
  localparam int NB = 3;
  localparam int BB = 2;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             rst_a, rst_b;
  logic [NA-1:0]    empty_a, rd_a;
  logic [NA*DW-1:0] din_a;
  logic [DW-1:0]    data_a;
  logic [1:0]       ch_a;
  logic             valid_a, ready_a, busy_a;
  logic [NB-1:0]    empty_b, rd_b;
  logic [NB*DW-1:0] din_b;
  logic [DW-1:0]    data_b;
  logic [1:0]       ch_b;
  logic             valid_b, ready_b, busy_b;

  fifo_rr_drain_arbiter #(.CH_AMOUNT(NA), .DATA_WIDTH(DW), .BURST_LEN(BA)) dut_a (
    .clk_i(clk_i), .rst_i(rst_a), .fifo_empty_i(empty_a), .fifo_rd_data_i(din_a),
    .fifo_rd_o(rd_a), .data_o(data_a), .ch_o(ch_a), .valid_o(valid_a),
    .ready_i(ready_a), .busy_o(busy_a));

  fifo_rr_drain_arbiter #(.CH_AMOUNT(NB), .DATA_WIDTH(DW), .BURST_LEN(BB)) dut_b (
    .clk_i(clk_i), .rst_i(rst_b), .fifo_empty_i(empty_b), .fifo_rd_data_i(din_b),
    .fifo_rd_o(rd_b), .data_o(data_b), .ch_o(ch_b), .valid_o(valid_b),
    .ready_i(ready_b), .busy_o(busy_b));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Environment: source FIFOs, traffic knobs, observation logs
  logic [7:0] fq [2][4][$];
  int n_ch [2] = '{NA, NB};
  int blen [2] = '{BA, BB};
  int push_pct [2];
  int rdy_pct  [2];
  int pop_cyc [2][$];
  int xfer_ch [2][$];

  // Reference model: grant owner, words in this grant, pending output word
  bit m_gnt [2];
  int m_owner [2];
  int m_last [2];
  int m_cnt [2];
  bit m_valid [2];
  int xq [2][$];

  bit p_pop [2];
  bit p_rdy [2];
  int p_emp [2];
  int p_rd [2];
  int p_head [2];

  int exp35_rd [6]   = '{0, 4, 4, 4, 0, 0};
  int exp35_busy [6] = '{0, 1, 1, 1, 1, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic string tg(input string s, input int i);
    return $sformatf("%s_%s", s, (i == 0) ? "a" : "b");
  endfunction

  function automatic int rd_of(input int i);    return (i == 0) ? int'(rd_a)    : int'(rd_b);    endfunction
  function automatic int busy_of(input int i);  return (i == 0) ? int'(busy_a)  : int'(busy_b);  endfunction
  function automatic int valid_of(input int i); return (i == 0) ? int'(valid_a) : int'(valid_b); endfunction
  function automatic int ch_of(input int i);    return (i == 0) ? int'(ch_a)    : int'(ch_b);    endfunction
  function automatic int data_of(input int i);  return (i == 0) ? int'(data_a)  : int'(data_b);  endfunction
  function automatic int ready_of(input int i); return (i == 0) ? int'(ready_a) : int'(ready_b); endfunction

  function automatic int empties(input int i);
    int e;
    e = 0;
    for (int k = 0; k < n_ch[i]; k++) if (fq[i][k].size() == 0) e = e | (1 << k);
    return e;
  endfunction

  task automatic drive();
    for (int k = 0; k < NA; k++) begin
      empty_a[k] = (fq[0][k].size() == 0);
      din_a[k*DW +: DW] = empty_a[k] ? 8'($urandom) : fq[0][k][0];
    end
    for (int k = 0; k < NB; k++) begin
      empty_b[k] = (fq[1][k].size() == 0);
      din_b[k*DW +: DW] = empty_b[k] ? 8'($urandom) : fq[1][k][0];
    end
    ready_a = (int'($urandom_range(0, 99)) < rdy_pct[0]);
    ready_b = (int'($urandom_range(0, 99)) < rdy_pct[1]);
  endtask

  task automatic push_words(input int i, input int k, input int n);
    for (int j = 0; j < n; j++) fq[i][k].push_back(8'($urandom));
  endtask

  // Mid-cycle: compare DUT against the model, remember what the coming edge does.
  task automatic pre_edge();
    #1;
    for (int i = 0; i < 2; i++) begin
      int emp, rd, exp_rd;
      bit rdy;
      emp = empties(i);
      rd  = rd_of(i);
      rdy = (ready_of(i) != 0);
      p_emp[i] = emp;
      p_rd[i]  = rd;
      p_rdy[i] = rdy;
      p_pop[i] = m_gnt[i] && (((emp >> m_owner[i]) & 1) == 0)
                 && (!m_valid[i] || rdy) && (m_cnt[i] < blen[i]);
      exp_rd = p_pop[i] ? (1 << m_owner[i]) : 0;
      check(tg("rd", i), rd, exp_rd);
      check(tg("busy", i), busy_of(i), m_gnt[i]);
      check(tg("valid", i), valid_of(i), m_valid[i]);
      if (m_valid[i]) begin
        check(tg("sb_depth", i), xq[i].size(), 1);
        if (xq[i].size() > 0) check(tg("word", i), ch_of(i) * 256 + data_of(i), xq[i][0]);
      end
      check(tg("onehot", i), ($countones(rd) <= 1), 1);
      check(tg("pop_on_empty", i), rd & emp, 0);
      if (rd != 0) pop_cyc[i].push_back(cyc);
      if (valid_of(i) != 0 && rdy) xfer_ch[i].push_back(ch_of(i));
      p_head[i] = 0;
      if (p_pop[i]) p_head[i] = int'(fq[i][m_owner[i]][0]);
    end
  endtask

  // Just after the edge: retire pops, advance the model, add new traffic.
  task automatic post_edge();
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int emp, c;
      bit found;
      emp = p_emp[i];
      for (int k = 0; k < n_ch[i]; k++)
        if (((p_rd[i] >> k) & 1) != 0 && fq[i][k].size() > 0) fq[i][k].delete(0);
      if (m_valid[i] && p_rdy[i] && xq[i].size() > 0) xq[i].delete(0);
      if (!m_gnt[i]) begin
        if (m_valid[i] && p_rdy[i]) m_valid[i] = 1'b0;
        if (emp != (1 << n_ch[i]) - 1) begin
          found = 1'b0;
          for (int k = 1; k <= n_ch[i]; k++) begin
            c = (m_last[i] + k) % n_ch[i];
            if (!found && ((emp >> c) & 1) == 0) begin
              m_owner[i] = c;
              found = 1'b1;
            end
          end
          m_gnt[i] = 1'b1;
          m_cnt[i] = 0;
        end
      end else if (p_pop[i]) begin
        xq[i].push_back(m_owner[i] * 256 + p_head[i]);
        m_valid[i] = 1'b1;
        m_cnt[i]++;
        if (m_cnt[i] == blen[i]) begin
          m_gnt[i]  = 1'b0;
          m_last[i] = m_owner[i];
        end
      end else begin
        if (m_valid[i] && p_rdy[i]) m_valid[i] = 1'b0;
        if (((emp >> m_owner[i]) & 1) != 0) begin
          m_gnt[i]  = 1'b0;
          m_last[i] = m_owner[i];
        end
      end
      for (int k = 0; k < n_ch[i]; k++)
        if (fq[i][k].size() < 16 && int'($urandom_range(0, 99)) < push_pct[i])
          fq[i][k].push_back(8'($urandom));
    end
    drive();
  endtask

  task automatic cycle();
    pre_edge();
    @(posedge clk_i);
    #1;
    post_edge();
  endtask

  task automatic do_reset(input bit clear_q);
    rst_a = 1'b1;
    rst_b = 1'b1;
    if (clear_q)
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 4; k++) fq[i][k].delete();
    drive();
    #1;
    for (int i = 0; i < 2; i++) begin
      check(tg("rst_rd", i), rd_of(i), 0);
      check(tg("rst_valid", i), valid_of(i), 0);
      check(tg("rst_busy", i), busy_of(i), 0);
      m_gnt[i]   = 1'b0;
      m_last[i]  = n_ch[i] - 1;
      m_cnt[i]   = 0;
      m_valid[i] = 1'b0;
      xq[i].delete();
      pop_cyc[i].delete();
      xfer_ch[i].delete();
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive();
  endtask

  initial begin
    int saved, left;
    rst_a = 1'b0;
    rst_b = 1'b0;
    push_pct = '{0, 0};
    rdy_pct  = '{100, 100};
    #1;
    do_reset(1'b1);

    // Lone requester ch2 with 3 words
    push_words(0, 2, 3);
    drive();
    for (int c = 0; c < 6; c++) begin
      pre_edge();
      check("s35_rd", rd_a, exp35_rd[c]);
      check("s35_busy", busy_a, exp35_busy[c]);
      @(posedge clk_i);
      #1;
      post_edge();
    end
    check("s35_xfers", xfer_ch[0].size(), 3);
    foreach (xfer_ch[0][k]) check("s35_ch", xfer_ch[0][k], 2);

    // All four channels saturated: 4-word bursts, one bubble between them
    do_reset(1'b1);
    for (int k = 0; k < NA; k++) push_words(0, k, 10);
    drive();
    repeat (70) cycle();
    check("s36_xfers", xfer_ch[0].size(), 40);
    if (xfer_ch[0].size() >= 40) begin
      for (int k = 0; k < 32; k++) check("s36_ch", xfer_ch[0][k], (k / 4) % 4);
      for (int k = 32; k < 40; k++) check("s36_tail_ch", xfer_ch[0][k], (k - 32) / 2);
    end
    if (pop_cyc[0].size() >= 32) check("s36_rate", pop_cyc[0][31] - pop_cyc[0][0], 38);

    // Back-pressure mid-burst on ch1
    do_reset(1'b1);
    push_words(0, 1, 10);
    drive();
    for (int c = 0; c < 20 && pop_cyc[0].size() < 2; c++) cycle();
    check("s37_start", pop_cyc[0].size(), 2);
    rdy_pct[0] = 0;
    drive();
    saved = int'(ch_a) * 256 + int'(data_a);
    for (int c = 0; c < 5; c++) begin
      pre_edge();
      check("s37_busy", busy_a, 1);
      check("s37_rd", rd_a, 0);
      check("s37_hold", int'(ch_a) * 256 + int'(data_a), saved);
      @(posedge clk_i);
      #1;
      post_edge();
    end
    rdy_pct[0] = 100;
    drive();
    repeat (30) cycle();
    check("s37_xfers", xfer_ch[0].size(), 10);
    foreach (xfer_ch[0][k]) check("s37_ch", xfer_ch[0][k], 1);

    // Three channels: after ch2's grant, ch0 wins over a still-pending ch2
    do_reset(1'b1);
    push_words(1, 2, 4);
    drive();
    repeat (3) cycle();
    push_words(1, 0, 1);
    drive();
    repeat (12) cycle();
    check("s38_xfers", xfer_ch[1].size(), 5);
    if (xfer_ch[1].size() >= 3) begin
      check("s38_first", xfer_ch[1][0], 2);
      check("s38_wrap", xfer_ch[1][2], 0);
    end

    // Reset during a ch3 burst, then ch0 and ch3 both pending
    do_reset(1'b1);
    push_words(0, 3, 6);
    drive();
    for (int c = 0; c < 20 && pop_cyc[0].size() < 1; c++) cycle();
    check("s39_start", pop_cyc[0].size(), 1);
    push_words(0, 0, 3);
    do_reset(1'b0);
    repeat (12) cycle();
    check("s39_first_ch", (xfer_ch[0].size() > 0) ? xfer_ch[0][0] : 99, 0);

    // Random traffic on both instances, then drain
    do_reset(1'b1);
    for (int blk = 0; blk < 10; blk++) begin
      for (int i = 0; i < 2; i++) begin
        push_pct[i] = int'($urandom_range(5, 60));
        rdy_pct[i]  = int'($urandom_range(20, 100));
      end
      repeat (1000) cycle();
    end
    push_pct = '{0, 0};
    rdy_pct  = '{100, 100};
    repeat (300) cycle();
    for (int i = 0; i < 2; i++) begin
      left = 0;
      for (int k = 0; k < 4; k++) left += fq[i][k].size();
      check(tg("drained", i), left, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
